// File: rtl/par_to_ser_tx_if.sv
// par_to_ser_tx_if: load handshake and serial link of the parallel-to-serial transmitter
interface par_to_ser_tx_if #(parameter int WIDTH = 8);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             serial_data;
  logic             data_ena;
  logic             busy;
  logic             byte_done;
  modport master (output load_valid, load_data, input load_ready, serial_data, data_ena, busy, byte_done);
  modport slave  (input load_valid, load_data, output load_ready, serial_data, data_ena, busy, byte_done);
endinterface

// File: rtl/par_to_ser_tx.sv
// par_to_ser_tx: shifts a loaded word out MSB first, one data_ena strobe per bit
module par_to_ser_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 0
) (
  input logic           clk,
  input logic           reset_n,
  par_to_ser_tx_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [BW-1:0] BIT_TOP  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             done_q, done_d;
  logic             bit_end, last_bit, accept;
  assign bit_end         = state_q == SHIFT && cyc_cnt_q == CYC_LAST;
  assign last_bit        = bit_end && bit_cnt_q == '0;
  // the last-bit slot doubles as a load slot so words can run back to back
  assign bus.load_ready  = reset_n && (state_q == IDLE || (GAP_CYCLES == 0 && last_bit));
  assign accept          = bus.load_valid && bus.load_ready;
  assign bus.serial_data = state_q == SHIFT && sreg_q[WIDTH-1];
  assign bus.data_ena    = bit_end;
  assign bus.busy        = state_q != IDLE;
  assign bus.byte_done   = done_q;
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = last_bit;
    if (accept) begin
      state_d   = SHIFT;
      sreg_d    = bus.load_data;
      bit_cnt_d = BIT_TOP;
      cyc_cnt_d = '0;
    end else if (state_q == SHIFT) begin
      cyc_cnt_d = bit_end ? '0 : cyc_cnt_q + 1'b1;
      sreg_d    = bit_end ? {sreg_q[WIDTH-2:0], 1'b0} : sreg_q;
      bit_cnt_d = bit_end && !last_bit ? bit_cnt_q - 1'b1 : bit_cnt_q;
      gap_cnt_d = '0;
      state_d   = last_bit ? (GAP_CYCLES > 0 ? GAP : IDLE) : SHIFT;
    end else if (state_q == GAP) begin
      gap_cnt_d = gap_cnt_q == GAP_LAST ? '0 : gap_cnt_q + 1'b1;
      state_d   = gap_cnt_q == GAP_LAST ? IDLE : GAP;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_par_to_ser_tx.sv
// tb_par_to_ser_tx: directed and round-trip checks over four BIT_CYCLES/GAP_CYCLES configurations
module tb_par_to_ser_tx;
  localparam int BCS [4] = '{1, 1, 3, 3};
  localparam int GPS [4] = '{0, 2, 0, 2};
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] lv = '0;
  logic [7:0] ld [4];
  logic [3:0] rdy, sd, en, bz, dn;
  int         n_vec = 0;
  int         n_bad = 0;
  logic       rt_on = 1'b0;
  int         rt_cfg = 0;
  logic [7:0] q [$];
  logic [7:0] rx = '0;
  int         ecnt = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : gen_cfg
    par_to_ser_tx_if #(.WIDTH(8)) bus ();
    assign bus.load_valid = lv[g];
    assign bus.load_data  = ld[g];
    assign rdy[g] = bus.load_ready;
    assign sd[g]  = bus.serial_data;
    assign en[g]  = bus.data_ena;
    assign bz[g]  = bus.busy;
    assign dn[g]  = bus.byte_done;
    par_to_ser_tx #(.WIDTH(8), .BIT_CYCLES(BCS[g]), .GAP_CYCLES(GPS[g])) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input int i, input logic esd, een, ebz, edn, erdy);
    chk({tag, " serial_data"}, sd[i], esd);
    chk({tag, " data_ena"}, en[i], een);
    chk({tag, " busy"}, bz[i], ebz);
    chk({tag, " byte_done"}, dn[i], edn);
    chk({tag, " load_ready"}, rdy[i], erdy);
  endtask
  // one default-config word; noise drives a rejected 0xFF load during cycles 2-5
  task automatic send_check(input string tag, input logic [7:0] w, input logic noise);
    tick();
    lv[0] = 1'b1;
    ld[0] = w;
    @(negedge clk);
    chk({tag, " c0 load_ready"}, rdy[0], 1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      lv[0] = noise && c >= 2 && c <= 5;
      ld[0] = noise && c >= 2 ? 8'hFF : w;
      @(negedge clk);
      outs($sformatf("%s c%0d", tag, c), 0, c <= 8 ? w[8-c] : 1'b0, c <= 8, c <= 8, c == 9, c >= 8);
    end
  endtask
  always @(negedge clk) begin
    if (!rt_on) ecnt <= 0;
    else begin
      if (dn[rt_cfg]) begin
        chk($sformatf("rt%0d pending", rt_cfg), q.size() > 0, 1);
        if (q.size() > 0) chk($sformatf("rt%0d word", rt_cfg), rx, q.pop_front());
        chk($sformatf("rt%0d ena count", rt_cfg), ecnt, 8);
      end
      ecnt <= (dn[rt_cfg] ? 0 : ecnt) + (en[rt_cfg] ? 1 : 0);
      rx   <= en[rt_cfg] ? {rx[6:0], sd[rt_cfg]} : rx;
    end
  end
  initial begin
    logic [7:0] w;
    int         n, b;
    logic       acc;
    for (int i = 0; i < 4; i++) ld[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs("reset", 0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    send_check("t1", 8'hA5, 1'b0);
    tick();
    lv[0] = 1'b1;
    ld[0] = 8'hFF;
    @(negedge clk);
    chk("t2 c0 load_ready", rdy[0], 1);
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1) ld[0] = 8'h00;
      if (c == 9) lv[0] = 1'b0;
      @(negedge clk);
      outs($sformatf("t2 c%0d", c), 0, c <= 8, c <= 16, c <= 16, c == 9 || c == 17, c == 8 || c >= 16);
    end
    w = 8'h81;
    tick();
    lv[3] = 1'b1;
    ld[3] = w;
    @(negedge clk);
    chk("t3 c0 load_ready", rdy[3], 1);
    for (int c = 1; c <= 27; c++) begin
      tick();
      lv[3] = 1'b0;
      b = c <= 24 ? (c - 1) / 3 : 0;
      @(negedge clk);
      outs($sformatf("t3 c%0d", c), 3, c <= 24 ? w[7-b] : 1'b0, c <= 24 && c % 3 == 0, c <= 26, c == 25, c == 27);
    end
    send_check("t4", 8'h3C, 1'b1);
    w = 8'hF0;
    tick();
    lv[0] = 1'b1;
    ld[0] = w;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      tick();
      lv[0] = 1'b0;
      @(negedge clk);
      outs($sformatf("t5 c%0d", c), 0, w[8-c], 1, 1, 0, 0);
    end
    tick();
    reset_n = 1'b0;
    #1;
    outs("t5 reset edge", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    outs("t5 reset c5", 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    outs("t5 reset c6", 0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    for (int c = 7; c <= 9; c++) begin
      @(negedge clk);
      outs($sformatf("t5 after c%0d", c), 0, 0, 0, 0, 0, 1);
      tick();
    end
    send_check("t5b", 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rt_cfg = i;
      tick();
      rt_on = 1'b1;
      for (int k = 0; k < 256; k++) begin
        lv[i] = 1'b1;
        ld[i] = 8'($urandom);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
          @(negedge clk);
          acc = rdy[i];
          tick();
          n++;
        end
        if (!acc) chk($sformatf("rt%0d accept", i), acc, 1);
        else q.push_back(ld[i]);
        if ($urandom_range(3) == 0) begin
          lv[i] = 1'b0;
          tick();
        end
      end
      lv[i] = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 200) begin
        tick();
        n++;
      end
      chk($sformatf("rt%0d drain", i), q.size(), 0);
      q.delete();
      tick();
      rt_on = 1'b0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
